instruction_loader: RTL
=======================

Name: instruction_loader

Overview:
Writer side of the instruction-fetch memory write port. Receives a byte stream, for example from the UART receiver, and packs each group of four bytes into a 32-bit instruction. Each instruction is written to consecutive word addresses (0, 4, 8, …) using a single-cycle write strobe. While loading, it holds the pipeline halted. Loading ends on an end-of-program word or when memory is full, and the halt is then released.

Parameters:
NB_DATA, 32, instruction word width
NB_ADDR, 32, byte-address width driven to the instruction memory
MEM_WORDS, 256, instruction memory depth in words; writes never exceed index MEM_WORDS-1
END_WORD, 32'hFFFFFFFF, end-of-program marker; written to memory, then loading stops

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_start  in  1  pulse: begin a new load (accepted in IDLE or DONE only)
i_rx_data  in  8  received byte
i_rx_valid  in  1  one-cycle strobe: i_rx_data is valid
o_write_instruction  out  1  one-cycle write strobe to instruction memory
o_instruction  out  NB_DATA  word to write
o_address  out  NB_ADDR  byte address of the word (multiple of 4)
o_halt  out  1  pipeline hold, high while loading
o_busy  out  1  high in LOAD
o_done  out  1  high in DONE until the next i_start
o_full  out  1  load ended because memory filled without END_WORD

Behaviour:
- Reset (i_reset=0, asynchronous): state IDLE, byte counter 0, word index 0, shift register 0. All outputs are 0.
- States: IDLE, LOAD, DONE.
- IDLE: on i_start=1, go to LOAD, set o_halt=1, clear index and byte counter. i_rx_valid is ignored.
- LOAD: each i_rx_valid=1 shifts the byte in. Byte order is big-endian: the first byte lands in bits [31:24], the fourth in [7:0]. The byte counter (2 bits) increments and wraps.
- On the edge that captures the 4th byte, all of the following are registered on that edge:
  - o_instruction <= assembled word
  - o_address <= index*4
  - o_write_instruction <= 1 for exactly the following cycle
  - index <= index+1
- A word write takes no extra cycles. A byte arriving on the cycle the strobe is high is captured into the next word; no byte is ever dropped.
- End condition: if the completed word equals END_WORD, it is still written, and the state goes to DONE on the same edge.
- Full condition: if the completed word is written to index MEM_WORDS-1 and is not END_WORD, the state goes to DONE with o_full=1.
- If END_WORD lands exactly at index MEM_WORDS-1, o_full=0.
- DONE: o_halt=0 and o_busy=0 from the first DONE cycle; o_done=1. Any in-flight write strobe still completes that cycle. i_rx_valid is ignored.
- On i_start in DONE: return to LOAD and clear o_done, o_full, index and byte counter. o_instruction and o_address keep their last values until the next write.
- i_start during LOAD is ignored; a partial word is kept.
- Outside write cycles, o_write_instruction=0. o_address and o_instruction are stable whenever the strobe is high.
- Reset mid-load aborts immediately: the partial word is lost and o_halt drops to 0.
- Width rule: o_address = {index, 2'b00}, zero-extended to NB_ADDR.

Test Plan:
1. Reset, then i_start, then bytes 10 10 10 10 / 12 34 56 78 / AB CD EF 01 / FE DC BA 98 / FF FF FF FF.
   - Exactly five strobes, with (addr, data) = (0,10101010), (4,12345678), (8,ABCDEF01), (C,FEDCBA98), (10,FFFFFFFF).
   - o_halt high from the cycle after i_start through the last byte; then o_done=1, o_halt=0, o_full=0.
2. Back-to-back i_rx_valid every cycle for 8 bytes: two strobes at addresses 0 and 4. No byte lost, including the byte arriving during the first strobe cycle.
3. MEM_WORDS=4, 16 bytes of 00..0F, none matching END_WORD: strobes at addresses 0, 4, 8, C; then DONE with o_full=1. Further bytes produce no strobe.
4. Assert i_reset low after 6 bytes of a load: all outputs 0 asynchronously, no strobe. A new i_start followed by 11 22 33 44 writes 11223344 at address 0.
5. i_start pulsed mid-load after 2 bytes, then 2 more bytes: one word written at address 0 containing all 4 bytes. A second i_start in DONE restarts at address 0 and clears o_done.
6. i_rx_valid pulses in IDLE and in DONE: no strobe, index unchanged, o_halt stays 0.

Source files
------------

// File: rtl/instruction_loader.sv
// Packs a byte stream into 32-bit big-endian instructions and writes them to
// consecutive word addresses of the instruction memory, holding the pipeline halted meanwhile.
module instruction_loader #(
  parameter int unsigned         NB_DATA   = 32,
  parameter int unsigned         NB_ADDR   = 32,
  parameter int unsigned         MEM_WORDS = 256,
  parameter logic [NB_DATA-1:0]  END_WORD  = 32'hFFFF_FFFF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  output logic               o_write_instruction,
  output logic [NB_DATA-1:0] o_instruction,
  output logic [NB_ADDR-1:0] o_address,
  output logic               o_halt,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_full
);

  localparam int unsigned        IDX_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(MEM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t             state;
  logic [1:0]         byte_cnt;
  logic [IDX_W-1:0]   index;
  logic [NB_DATA-9:0] shift;
  logic [NB_DATA-1:0] word_c;

  // Word as it would look with the current byte appended (big-endian fill).
  always_comb begin
    word_c = {shift, i_rx_data};
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state               <= IDLE;
      byte_cnt            <= 2'd0;
      index               <= '0;
      shift               <= '0;
      o_write_instruction <= 1'b0;
      o_instruction       <= '0;
      o_address           <= '0;
      o_halt              <= 1'b0;
      o_busy              <= 1'b0;
      o_done              <= 1'b0;
      o_full              <= 1'b0;
    end else begin
      o_write_instruction <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (i_start) begin
            state    <= LOAD;
            o_halt   <= 1'b1;
            o_busy   <= 1'b1;
            o_done   <= 1'b0;
            o_full   <= 1'b0;
            index    <= '0;
            byte_cnt <= 2'd0;
            shift    <= '0;
          end
        end
        LOAD: begin
          if (i_rx_valid) begin
            shift    <= word_c[NB_DATA-9:0];
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              o_instruction       <= word_c;
              o_address           <= NB_ADDR'({index, 2'b00});
              o_write_instruction <= 1'b1;
              index               <= index + IDX_W'(1);
              // End marker wins over full so a marker in the last slot is not flagged.
              if (word_c == END_WORD || index == LAST_IDX) begin
                state  <= DONE;
                o_halt <= 1'b0;
                o_busy <= 1'b0;
                o_done <= 1'b1;
                o_full <= (word_c != END_WORD);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
